hilo_muldiv_seq: RTL

Iterative multiply/divide sequencer that owns the HI/LO result registers of the multicycle datapath. The control FSM fires a one-cycle start with an opcode-derived op and the two register operands, then holds in its execute state while busy is high. The block runs a shift-add multiply or a restoring divide over WIDTH cycles, presents the HI/LO result, and pulses hiWrite/loWrite/done for one cycle.

---
 rtl/hilo_muldiv_seq.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/hilo_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : hilo_muldiv_seq
// Description : Iterative multiply/divide sequencer owning the HI/LO result
//               registers. Shift-add multiply (LSB first) or restoring divide
//               (MSB first), one bit per cycle over WIDTH cycles, with sign
//               handling done by magnitude conversion and a final fix-up.
// Ports       : clk, reset        - clock, synchronous active-high reset
//               start, op, a, b   - request pulse, opcode, operands (IDLE only)
//               busy              - high in every state except IDLE
//               done/hiWrite/loWrite - one-cycle result pulse
//               hi, lo            - HI/LO registers
//               div_by_zero       - sticky until next accepted start
// Revision    : 1.0 - initial release
// ============================================================================
module hilo_muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             hiWrite,
    output logic             loWrite,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int                 c_CNT_W    = $clog2(WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_ITER = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t               r_state;
    logic [1:0]           r_op;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [WIDTH-1:0]     r_mcand;    // multiplicand magnitude, or divisor magnitude
    logic [2*WIDTH-1:0]   r_acc;      // product accumulator; low half is dividend/quotient
    logic [WIDTH-1:0]     r_rem;      // partial remainder (always < divisor)
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_neg_res;
    logic                 r_neg_rem;
    logic                 r_zdiv;     // zero-divide result already loaded in PREP

    logic                 w_is_div;
    logic                 w_signed;
    logic [WIDTH-1:0]     w_abs_a;
    logic [WIDTH-1:0]     w_abs_b;
    logic [WIDTH:0]       w_addend;
    logic [WIDTH:0]       w_msum;
    logic [2*WIDTH-1:0]   w_acc_mul;
    logic [WIDTH:0]       w_shift;
    logic [WIDTH:0]       w_diff;
    logic                 w_fits;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_quo;
    logic [WIDTH-1:0]     w_rem;

    assign w_is_div = r_op[1];
    assign w_signed = r_op[0];

    // Magnitudes for signed ops; -(2^(W-1)) maps onto itself, which is the
    // correct unsigned magnitude.
    assign w_abs_a = (w_signed && r_a[WIDTH-1]) ? ({WIDTH{1'b0}} - r_a) : r_a;
    assign w_abs_b = (w_signed && r_b[WIDTH-1]) ? ({WIDTH{1'b0}} - r_b) : r_b;

    // Multiply step: conditionally add the multiplicand into the upper half,
    // then shift the whole accumulator right; the carry becomes the new MSB.
    assign w_addend  = r_acc[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}};
    assign w_msum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + w_addend;
    assign w_acc_mul = {w_msum, r_acc[WIDTH-1:1]};

    // Restoring divide step: bring in the next dividend bit and trial-subtract.
    assign w_shift = {r_rem, r_acc[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_mcand};
    assign w_fits  = ~w_diff[WIDTH];

    // Sign fix-up applied when loading HI/LO.
    assign w_prod = r_neg_res ? ({(2*WIDTH){1'b0}} - r_acc) : r_acc;
    assign w_quo  = r_neg_res ? ({WIDTH{1'b0}} - r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
    assign w_rem  = r_neg_rem ? ({WIDTH{1'b0}} - r_rem) : r_rem;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_op        <= 2'b00;
            r_a         <= '0;
            r_b         <= '0;
            r_mcand     <= '0;
            r_acc       <= '0;
            r_rem       <= '0;
            r_cnt       <= '0;
            r_neg_res   <= 1'b0;
            r_neg_rem   <= 1'b0;
            r_zdiv      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            hiWrite     <= 1'b0;
            loWrite     <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done    <= 1'b0;
            hiWrite <= 1'b0;
            loWrite <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op        <= op;
                        r_a         <= a;
                        r_b         <= b;
                        div_by_zero <= 1'b0;
                        busy        <= 1'b1;
                        r_state     <= S_PREP;
                    end
                end

                S_PREP: begin
                    r_neg_res <= w_signed & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
                    r_neg_rem <= w_signed & r_a[WIDTH-1];
                    r_rem     <= '0;
                    if (w_is_div && (r_b == '0)) begin
                        // Result is known now; the pass through FIX keeps the
                        // zero-divide done pulse at a fixed three-cycle latency.
                        hi          <= r_a;
                        lo          <= '1;
                        div_by_zero <= 1'b1;
                        r_zdiv      <= 1'b1;
                        r_state     <= S_FIX;
                    end else begin
                        r_zdiv  <= 1'b0;
                        r_cnt   <= c_CNT_INIT;
                        r_state <= S_ITER;
                        if (w_is_div) begin
                            r_acc   <= {{WIDTH{1'b0}}, w_abs_a};
                            r_mcand <= w_abs_b;
                        end else begin
                            r_acc   <= {{WIDTH{1'b0}}, w_abs_b};
                            r_mcand <= w_abs_a;
                        end
                    end
                end

                S_ITER: begin
                    if (w_is_div) begin
                        r_rem              <= w_fits ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
                        r_acc[WIDTH-1:0]   <= {r_acc[WIDTH-2:0], w_fits};
                    end else begin
                        r_acc <= w_acc_mul;
                    end
                    r_cnt <= r_cnt - c_CNT_ONE;
                    if (r_cnt == c_CNT_ONE) begin
                        r_state <= S_FIX;
                    end
                end

                S_FIX: begin
                    if (!r_zdiv) begin
                        if (w_is_div) begin
                            hi <= w_rem;
                            lo <= w_quo;
                        end else begin
                            hi <= w_prod[2*WIDTH-1:WIDTH];
                            lo <= w_prod[WIDTH-1:0];
                        end
                    end
                    done    <= 1'b1;
                    hiWrite <= 1'b1;
                    loWrite <= 1'b1;
                    r_state <= S_DONE;
                end

                S_DONE: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
